// File: rtl/gbuff_c_pkg.sv
// Shared constants and FSM state type for the buffer C controller.
//   ADDR_BITS / DATA_BITS / DEPTH : default buffer geometry
//   state_e                       : drain sequencer states
package gbuff_c_pkg;

  localparam int unsigned ADDR_BITS = 16;
  localparam int unsigned DATA_BITS = 128;
  localparam int unsigned DEPTH     = 16384;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/gbuff_c_raw_check.sv
// Read-after-write hazard comparator for the buffer C drain.
//   busy    : drain in progress
//   base    : first address of the drain window
//   cnt     : rows already written (before this cycle's handshake)
//   len     : total rows in the drain
//   rd_addr : requested read address
//   hazard  : read targets a row that has not been written yet
module gbuff_c_raw_check #(
  parameter int unsigned ADDR_BITS = gbuff_c_pkg::ADDR_BITS
) (
  input  logic                 busy,
  input  logic [ADDR_BITS-1:0] base,
  input  logic [ADDR_BITS-1:0] cnt,
  input  logic [ADDR_BITS-1:0] len,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 hazard
);

  localparam int unsigned WIDE_BITS = ADDR_BITS + 1;

  logic [WIDE_BITS-1:0] pend_lo;
  logic [WIDE_BITS-1:0] pend_hi;
  logic [WIDE_BITS-1:0] addr_w;

  // One extra bit so base+len cannot wrap at the top of the address space.
  assign pend_lo = WIDE_BITS'(base) + WIDE_BITS'(cnt);
  assign pend_hi = WIDE_BITS'(base) + WIDE_BITS'(len);
  assign addr_w  = WIDE_BITS'(rd_addr);

  assign hazard = busy && (addr_w >= pend_lo) && (addr_w < pend_hi);

endmodule

// File: rtl/gbuff_c_ctrl.sv
// Sequencer for the TPU output global buffer C.
//   drain_*         : drain command and status (start/base/len, busy/done/err)
//   acc_*           : valid/ready stream of result rows from the accumulators
//   rd_*            : pipelined CFU read port (request/ready, valid/data)
//   gb_wr_en/index/data_in   : buffer write port (buffer clocks on negedge)
//   gb_out/index_out/data_out: buffer read port
// Reads stall only while they target rows of the current drain not yet written.
module gbuff_c_ctrl #(
  parameter int unsigned ADDR_BITS = gbuff_c_pkg::ADDR_BITS,
  parameter int unsigned DATA_BITS = gbuff_c_pkg::DATA_BITS,
  parameter int unsigned DEPTH     = gbuff_c_pkg::DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 drain_start,
  input  logic [ADDR_BITS-1:0] drain_base,
  input  logic [ADDR_BITS-1:0] drain_len,
  input  logic                 acc_valid,
  output logic                 acc_ready,
  input  logic [DATA_BITS-1:0] acc_data,
  output logic                 drain_busy,
  output logic                 drain_done,
  output logic                 drain_err,
  input  logic                 rd_req,
  output logic                 rd_ready,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 gb_wr_en,
  output logic [ADDR_BITS-1:0] gb_index,
  output logic [DATA_BITS-1:0] gb_data_in,
  output logic                 gb_out,
  output logic [ADDR_BITS-1:0] gb_index_out,
  input  logic [DATA_BITS-1:0] gb_data_out
);

  import gbuff_c_pkg::*;

  localparam int unsigned WIDE_BITS = ADDR_BITS + 1;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [ADDR_BITS-1:0] len_q, len_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;

  logic                 acc_ready_q, acc_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0] wr_index_q, wr_index_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic                 rd_issue_q, rd_issue_d;
  logic [ADDR_BITS-1:0] rd_index_q, rd_index_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;

  logic                 hazard;
  logic                 acc_hs;
  logic                 rd_acc;
  logic [ADDR_BITS-1:0] cnt_inc;
  logic [WIDE_BITS-1:0] start_end;

  // Stall reads that would see a row of the active drain before it lands.
  gbuff_c_raw_check #(
    .ADDR_BITS (ADDR_BITS)
  ) u_raw_check (
    .busy    (busy_q),
    .base    (base_q),
    .cnt     (cnt_q),
    .len     (len_q),
    .rd_addr (rd_addr),
    .hazard  (hazard)
  );

  assign rd_ready  = ~hazard;
  assign rd_acc    = rd_req && rd_ready;
  assign acc_hs    = acc_ready_q && acc_valid;
  assign cnt_inc   = cnt_q + ADDR_BITS'(1);
  assign start_end = WIDE_BITS'(drain_base) + WIDE_BITS'(drain_len);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    wr_en_d    = 1'b0;
    wr_index_d = wr_index_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      IDLE: begin
        if (drain_start) begin
          if (drain_len == '0) begin
            base_d  = drain_base;
            len_d   = drain_len;
            cnt_d   = '0;
            state_d = DONE;
          end else if (start_end > WIDE_BITS'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            base_d  = drain_base;
            len_d   = drain_len;
            cnt_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        err_d = drain_start;
        if (acc_hs) begin
          wr_en_d    = 1'b1;
          wr_index_d = base_q + cnt_q;
          wr_data_d  = acc_data;
          cnt_d      = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        err_d   = drain_start;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    acc_ready_d = (state_d == DRAIN);
    busy_d      = (state_d == DRAIN);
    done_d      = (state_d == DONE);

    rd_issue_d  = rd_acc;
    rd_index_d  = rd_acc ? rd_addr : rd_index_q;
    // Buffer data is valid one cycle after the issue, sampled at its negedge.
    rd_valid_d  = rd_issue_q;
    rd_data_d   = rd_issue_q ? gb_data_out : rd_data_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_index_q  <= '0;
      wr_data_q   <= '0;
      rd_issue_q  <= 1'b0;
      rd_index_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_ready_q <= acc_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      wr_index_q  <= wr_index_d;
      wr_data_q   <= wr_data_d;
      rd_issue_q  <= rd_issue_d;
      rd_index_q  <= rd_index_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign acc_ready    = acc_ready_q;
  assign drain_busy   = busy_q;
  assign drain_done   = done_q;
  assign drain_err    = err_q;
  assign gb_wr_en     = wr_en_q;
  assign gb_index     = wr_index_q;
  assign gb_data_in   = wr_data_q;
  assign gb_out       = rd_issue_q;
  assign gb_index_out = rd_index_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_gbuff_c_ctrl.sv
// Self-checking bench for gbuff_c_ctrl with a negedge buffer C stand-in and a
// transaction-level reference model (drain window, written rows, read queue).
`timescale 1ns/1ps
module tb_gbuff_c_ctrl;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 128;
  localparam int unsigned DEPTH = 16384;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          drain_start;
  logic [AW-1:0] drain_base;
  logic [AW-1:0] drain_len;
  logic          acc_valid;
  logic          acc_ready;
  logic [DW-1:0] acc_data;
  logic          drain_busy;
  logic          drain_done;
  logic          drain_err;
  logic          rd_req;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          gb_wr_en;
  logic [AW-1:0] gb_index;
  logic [DW-1:0] gb_data_in;
  logic          gb_out;
  logic [AW-1:0] gb_index_out;
  logic [DW-1:0] gb_data_out;

  always #5 clk = ~clk;

  gbuff_c_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .drain_start  (drain_start),
    .drain_base   (drain_base),
    .drain_len    (drain_len),
    .acc_valid    (acc_valid),
    .acc_ready    (acc_ready),
    .acc_data     (acc_data),
    .drain_busy   (drain_busy),
    .drain_done   (drain_done),
    .drain_err    (drain_err),
    .rd_req       (rd_req),
    .rd_ready     (rd_ready),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .gb_wr_en     (gb_wr_en),
    .gb_index     (gb_index),
    .gb_data_in   (gb_data_in),
    .gb_out       (gb_out),
    .gb_index_out (gb_index_out),
    .gb_data_out  (gb_data_out)
  );

  // Buffer C stand-in: negedge write and read, old data on a same-edge collision.
  logic [DW-1:0] buf_mem [DEPTH];
  always @(negedge clk) begin
    if (gb_wr_en && int'(gb_index) < DEPTH) buf_mem[gb_index[13:0]] <= gb_data_in;
    if (gb_out) gb_data_out <= (int'(gb_index_out) < DEPTH) ? buf_mem[gb_index_out[13:0]] : {DW{1'bx}};
  end

  // Reference model state.
  bit            m_active, m_done_now;
  int unsigned   m_base, m_len, m_wr;
  logic [DW-1:0] m_mem [int];
  bit            p_acc, p_chk;
  logic [DW-1:0] p_data;

  // Expectations for the edge just taken by tick().
  bit            obs_rd_ready, exp_rd_ready, exp_err, exp_wr, exp_rd_acc, exp_rv, exp_rchk;
  logic [AW-1:0] exp_idx, exp_rd_idx;
  logic [DW-1:0] exp_wdata, exp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic idle_inputs();
    drain_start = 1'b0; drain_base = '0; drain_len = '0;
    acc_valid = 1'b0; acc_data = '0; rd_req = 1'b0; rd_addr = '0;
  endtask

  task automatic model_reset();
    m_active = 0; m_done_now = 0; m_base = 0; m_len = 0; m_wr = 0;
    p_acc = 0; p_chk = 0; p_data = '0;
  endtask

  // One clock: predict from the spec rules, take the edge, advance the model.
  task automatic tick();
    int unsigned a;
    bit act_n, done_n, started, new_chk;
    int unsigned nb, nl;
    logic [DW-1:0] new_data;
    #1;
    obs_rd_ready = rd_ready;
    a = int'(rd_addr);
    exp_rd_ready = !(m_active && a >= m_base + m_wr && a < m_base + m_len);
    exp_err = 0; exp_wr = 0; done_n = 0; started = 0; act_n = m_active; nb = 0; nl = 0;
    if (drain_start) begin
      if (m_active || m_done_now) exp_err = 1;
      else if (drain_len == '0) done_n = 1;
      else if (int'(drain_base) + int'(drain_len) > int'(DEPTH)) exp_err = 1;
      else begin started = 1; act_n = 1; nb = int'(drain_base); nl = int'(drain_len); end
    end
    if (m_active && acc_valid) begin
      exp_wr = 1; exp_idx = AW'(m_base + m_wr); exp_wdata = acc_data;
      m_mem[int'(m_base + m_wr)] = acc_data;
      m_wr++;
      if (m_wr == m_len) begin act_n = 0; done_n = 1; end
    end
    if (started) begin m_base = nb; m_len = nl; m_wr = 0; end
    exp_rd_acc = rd_req && exp_rd_ready;
    exp_rd_idx = rd_addr;
    new_chk  = (a < DEPTH) && m_mem.exists(int'(a));
    new_data = new_chk ? m_mem[int'(a)] : '0;
    exp_rv = p_acc; exp_rchk = p_acc && p_chk; exp_rdata = p_data;
    p_acc = exp_rd_acc; p_chk = new_chk; p_data = new_data;
    @(posedge clk); #1;
    m_active = act_n; m_done_now = done_n;
  endtask

  task automatic test_reset();
    idle_inputs(); rst_n = 1'b0; model_reset();
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if ({acc_ready, drain_busy, drain_done, drain_err, rd_ready, rd_valid, gb_wr_en, gb_out} !== 8'b0000_1000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00001000",
        {acc_ready, drain_busy, drain_done, drain_err, rd_ready, rd_valid, gb_wr_en, gb_out});
    end
    n_checks++;
    if (gb_index !== '0 || gb_index_out !== '0 || rd_data !== '0 || gb_data_in !== '0) begin
      n_fail++; $display("FAIL reset_buses: got idx=%h idx_out=%h rd_data=%h expected all 0", gb_index, gb_index_out, rd_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_drain();
    idle_inputs(); drain_start = 1'b1; drain_base = 16'h100; drain_len = 16'd4; tick(); drain_start = 1'b0;
    n_checks++;
    if (drain_busy !== 1'b1 || acc_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_start: got busy=%b ready=%b expected 1 1", drain_busy, acc_ready);
    end
    for (int i = 0; i < 4; i++) begin
      acc_valid = 1'b1; acc_data = DW'(32'hA0 + i); tick();
      n_checks++;
      if (gb_wr_en !== 1'b1 || gb_index !== AW'(32'h100 + i) || gb_data_in !== DW'(32'hA0 + i)) begin
        n_fail++; $display("FAIL basic_write%0d: got en=%b idx=%h data=%h expected 1 %h %h",
          i, gb_wr_en, gb_index, gb_data_in, 32'h100 + i, 32'hA0 + i);
      end
      n_checks++;
      if (drain_done !== (i == 3)) begin
        n_fail++; $display("FAIL basic_done%0d: got %b expected %b", i, drain_done, i == 3);
      end
    end
    acc_valid = 1'b0; tick();
    n_checks++;
    if ({drain_done, drain_busy, gb_wr_en, acc_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL basic_after: got %b expected 0000", {drain_done, drain_busy, gb_wr_en, acc_ready});
    end
    for (int i = 0; i < 6; i++) begin
      rd_req = (i < 4); rd_addr = AW'(32'h100 + i); tick();
      n_checks++;
      if (gb_out !== (i < 4) || (i < 4 && gb_index_out !== AW'(32'h100 + i))) begin
        n_fail++; $display("FAIL basic_issue%0d: got gb_out=%b idx=%h", i, gb_out, gb_index_out);
      end
      n_checks++;
      if (rd_valid !== (i >= 1 && i <= 4) || (i >= 1 && i <= 4 && rd_data !== DW'(32'hA0 + i - 1))) begin
        n_fail++; $display("FAIL basic_read%0d: got valid=%b data=%h expected data %h", i, rd_valid, rd_data, 32'hA0 + i - 1);
      end
    end
  endtask

  task automatic test_gapped_stall();
    int c, wr_edge, acc_edge;
    logic [DW-1:0] row;
    c = 0; wr_edge = -1; acc_edge = -1; row = '0;
    idle_inputs(); drain_start = 1'b1; drain_base = 16'h200; drain_len = 16'd8; tick(); drain_start = 1'b0;
    rd_req = 1'b1; rd_addr = 16'h205;
    while (c < 120 && (m_active || m_done_now || acc_edge < 0 || c <= acc_edge + 1)) begin
      acc_valid = ($urandom_range(0, 2) == 0);
      acc_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n_checks++;
      if (obs_rd_ready !== exp_rd_ready) begin
        n_fail++; $display("FAIL stall_ready c%0d: got %b expected %b", c, obs_rd_ready, exp_rd_ready);
      end
      n_checks++;
      if (gb_wr_en !== exp_wr) begin
        n_fail++; $display("FAIL stall_wr c%0d: got %b expected %b", c, gb_wr_en, exp_wr);
      end
      if (exp_wr && exp_idx == 16'h205) begin
        wr_edge = c; row = exp_wdata;
        n_checks++;
        if (obs_rd_ready !== 1'b0) begin
          n_fail++; $display("FAIL same_edge_stall: got rd_ready=%b expected 0", obs_rd_ready);
        end
      end
      if (exp_rd_acc) begin acc_edge = c; rd_req = 1'b0; end
      if (acc_edge >= 0 && c == acc_edge + 1) begin
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== row) begin
          n_fail++; $display("FAIL stall_data: got valid=%b data=%h expected 1 %h", rd_valid, rd_data, row);
        end
      end
      c++;
    end
    n_checks++;
    if (acc_edge < 0 || acc_edge != wr_edge + 1 || m_active) begin
      n_fail++; $display("FAIL stall_release: got accept edge %0d expected %0d", acc_edge, wr_edge + 1);
    end
    idle_inputs();
  endtask

  task automatic test_errors();
    idle_inputs(); drain_start = 1'b1; drain_base = 16'd16380; drain_len = 16'd8; tick(); idle_inputs();
    n_checks++;
    if ({drain_err, drain_busy, gb_wr_en} !== 3'b100) begin
      n_fail++; $display("FAIL err_range: got err/busy/wr=%b expected 100", {drain_err, drain_busy, gb_wr_en});
    end
    tick();
    n_checks++;
    if ({drain_err, drain_busy, gb_wr_en} !== 3'b000) begin
      n_fail++; $display("FAIL err_pulse: got err/busy/wr=%b expected 000", {drain_err, drain_busy, gb_wr_en});
    end
    drain_start = 1'b1; drain_base = 16'd16376; drain_len = 16'd8; tick(); drain_start = 1'b0;
    n_checks++;
    if ({drain_err, drain_busy} !== 2'b01) begin
      n_fail++; $display("FAIL err_edge_fit: got err/busy=%b expected 01", {drain_err, drain_busy});
    end
    for (int i = 0; i < 8; i++) begin
      acc_valid = 1'b1; acc_data = DW'(32'h5500 + i);
      drain_start = (i == 2); drain_base = '0; drain_len = 16'd1;
      tick();
      n_checks++;
      if (gb_wr_en !== 1'b1 || gb_index !== AW'(16376 + i) || gb_data_in !== DW'(32'h5500 + i)) begin
        n_fail++; $display("FAIL err_busy_write%0d: got en=%b idx=%0d expected 1 %0d", i, gb_wr_en, gb_index, 16376 + i);
      end
      n_checks++;
      if (drain_err !== (i == 2) || drain_done !== (i == 7)) begin
        n_fail++; $display("FAIL err_busy_flags%0d: got err=%b done=%b", i, drain_err, drain_done);
      end
    end
    idle_inputs(); tick();
  endtask

  task automatic test_zero_len();
    idle_inputs(); drain_start = 1'b1; drain_base = 16'h50; drain_len = '0; tick();
    n_checks++;
    if ({drain_done, drain_busy, gb_wr_en, acc_ready, drain_err} !== 5'b10000) begin
      n_fail++; $display("FAIL zero_len: got done/busy/wr/ready/err=%b expected 10000",
        {drain_done, drain_busy, gb_wr_en, acc_ready, drain_err});
    end
    drain_len = 16'd2; tick();
    n_checks++;
    if ({drain_done, drain_busy, drain_err} !== 3'b001) begin
      n_fail++; $display("FAIL start_in_done: got done/busy/err=%b expected 001", {drain_done, drain_busy, drain_err});
    end
    idle_inputs(); tick();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] row;
    idle_inputs(); drain_start = 1'b1; drain_base = 16'h400; drain_len = 16'd6; tick(); drain_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      acc_valid = 1'b1; acc_data = {$urandom, $urandom, $urandom, $urandom}; tick();
    end
    acc_valid = 1'b0; rd_req = 1'b1; rd_addr = 16'h100; tick(); idle_inputs();
    rst_n = 1'b0; #1;
    n_checks++;
    if ({acc_ready, drain_busy, drain_done, drain_err, rd_ready, rd_valid, gb_wr_en, gb_out} !== 8'b0000_1000) begin
      n_fail++; $display("FAIL reset_mid: got %b expected 00001000",
        {acc_ready, drain_busy, drain_done, drain_err, rd_ready, rd_valid, gb_wr_en, gb_out});
    end
    model_reset();
    @(posedge clk); #1;
    n_checks++;
    if (rd_valid !== 1'b0 || rd_data !== '0) begin
      n_fail++; $display("FAIL reset_drop: got valid=%b data=%h expected 0 0", rd_valid, rd_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    row = {$urandom, $urandom, $urandom, $urandom};
    drain_start = 1'b1; drain_base = '0; drain_len = 16'd1; tick(); drain_start = 1'b0;
    acc_valid = 1'b1; acc_data = row; tick(); acc_valid = 1'b0;
    n_checks++;
    if (gb_wr_en !== 1'b1 || gb_index !== '0 || gb_data_in !== row || drain_done !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_drain: got en=%b idx=%h done=%b expected 1 0 1", gb_wr_en, gb_index, drain_done);
    end
    rd_req = 1'b1; rd_addr = '0; tick(); rd_req = 1'b0; tick();
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== row) begin
      n_fail++; $display("FAIL post_reset_read: got valid=%b data=%h expected 1 %h", rd_valid, rd_data, row);
    end
  endtask

  task automatic test_random();
    int c, tail;
    int unsigned len, base;
    for (int r = 0; r < 4; r++) begin
      len  = $urandom_range(1, 24);
      base = (r == 0) ? DEPTH - len : $urandom_range(0, DEPTH - len);
      idle_inputs(); drain_start = 1'b1; drain_base = AW'(base); drain_len = AW'(len);
      c = 0; tail = 0;
      while (c < 400 && tail < 4) begin
        tick();
        n_checks++;
        if (obs_rd_ready !== exp_rd_ready) begin
          n_fail++; $display("FAIL rnd_ready r%0d c%0d: got %b expected %b", r, c, obs_rd_ready, exp_rd_ready);
        end
        n_checks++;
        if ({drain_busy, acc_ready, drain_done, drain_err, gb_wr_en, gb_out} !==
            {m_active, m_active, m_done_now, exp_err, exp_wr, exp_rd_acc}) begin
          n_fail++; $display("FAIL rnd_flags r%0d c%0d: got %b expected %b", r, c,
            {drain_busy, acc_ready, drain_done, drain_err, gb_wr_en, gb_out},
            {m_active, m_active, m_done_now, exp_err, exp_wr, exp_rd_acc});
        end
        if (exp_wr) begin
          n_checks++;
          if (gb_index !== exp_idx || gb_data_in !== exp_wdata) begin
            n_fail++; $display("FAIL rnd_write r%0d c%0d: got idx=%h expected %h", r, c, gb_index, exp_idx);
          end
        end
        if (exp_rd_acc) begin
          n_checks++;
          if (gb_index_out !== exp_rd_idx) begin
            n_fail++; $display("FAIL rnd_issue r%0d c%0d: got %h expected %h", r, c, gb_index_out, exp_rd_idx);
          end
        end
        n_checks++;
        if (rd_valid !== exp_rv || (exp_rchk && rd_data !== exp_rdata)) begin
          n_fail++; $display("FAIL rnd_read r%0d c%0d: got valid=%b data=%h expected %b %h", r, c, rd_valid, rd_data, exp_rv, exp_rdata);
        end
        drain_start = (m_active || m_done_now) && ($urandom_range(0, 19) == 0);
        drain_base  = AW'($urandom); drain_len = AW'($urandom_range(0, 40));
        acc_valid   = ($urandom_range(0, 9) < 6);
        acc_data    = {$urandom, $urandom, $urandom, $urandom};
        rd_req      = ($urandom_range(0, 9) < 6);
        case ($urandom_range(0, 6))
          0:       rd_addr = AW'($urandom);
          1:       rd_addr = AW'($urandom_range(16370, 16383));
          default: rd_addr = AW'(m_base + $urandom_range(0, m_len));
        endcase
        if (!m_active && !m_done_now) tail++;
        c++;
      end
      n_checks++;
      if (m_active) begin
        n_fail++; $display("FAIL rnd_timeout r%0d: drain still active after %0d cycles", r, c);
      end
    end
    idle_inputs(); tick(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_drain();
    test_gapped_stall();
    test_errors();
    test_zero_len();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
